// File: rtl/ct_spsram_2048x32_ctrl_pkg.sv
// Shared widths, FIFO sizing and FSM encoding for the 2048x32 SRAM controller.
package ct_spsram_2048x32_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W    = 11;
  localparam int unsigned SRAM_DATA_W    = 32;
  localparam int unsigned RSP_FIFO_DEPTH = 2;
  localparam int unsigned RSP_FIFO_PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned RSP_FIFO_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// Two-entry read-response FIFO; head is presented combinationally from storage.
module ct_spsram_ctrl_rsp_fifo
  import ct_spsram_2048x32_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      pop_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic [RSP_FIFO_CNT_W-1:0] count_o
);

  logic [DATA_WIDTH-1:0]     mem_q [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_PTR_W-1:0] wr_ptr_q;
  logic [RSP_FIFO_PTR_W-1:0] rd_ptr_q;
  logic [RSP_FIFO_CNT_W-1:0] cnt_q;

  // Storage, pointers and occupancy; reset empties the FIFO and zeroes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + RSP_FIFO_PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + RSP_FIFO_PTR_W'(1);
      cnt_q <= cnt_q + RSP_FIFO_CNT_W'(push_i) - RSP_FIFO_CNT_W'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Single-port SRAM controller: clear sweep after reset/clear, then byte-masked
// writes and pipelined reads with a 2-entry response FIFO.
module ct_spsram_2048x32_ctrl
  import ct_spsram_2048x32_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned          DATA_WIDTH = SRAM_DATA_W,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL  = DATA_WIDTH'(32'h0)
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    req_vld,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    req_rdy,
  output logic                    rsp_vld,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rsp_rdy,
  input  logic                    clr_vld,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic                    CEN,
  output logic                    GWEN,
  output logic [DATA_WIDTH-1:0]   WEN,
  output logic [DATA_WIDTH-1:0]   D,
  input  logic [DATA_WIDTH-1:0]   Q
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OCC_W = RSP_FIFO_CNT_W + 1;

  ctrl_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
  logic                      inflight_q, inflight_d;
  logic [RSP_FIFO_CNT_W-1:0] fifo_cnt;
  logic [DATA_WIDTH-1:0]     fifo_rdata;
  logic                      rsp_pop;
  logic                      rd_room;

  assign rsp_vld   = (fifo_cnt != '0);
  assign rsp_rdata = fifo_rdata;
  assign rsp_pop   = rsp_vld & rsp_rdy;
  // A read may issue only if its response has a guaranteed FIFO slot.
  assign rd_room   = (OCC_W'(fifo_cnt) + OCC_W'(inflight_q) - OCC_W'(rsp_pop))
                     < OCC_W'(RSP_FIFO_DEPTH);

  // State, sweep pointer and read-inflight registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state and SRAM port drive; port is idle-valued while in reset.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    inflight_d = 1'b0;
    req_rdy    = 1'b0;
    init_done  = 1'b0;
    CEN        = 1'b1;
    GWEN       = 1'b1;
    WEN        = '1;
    A          = '0;
    D          = '0;
    if (cpurst_b) begin
      case (state_q)
        ST_INIT: begin
          CEN   = 1'b0;
          GWEN  = 1'b0;
          WEN   = '0;
          A     = ptr_q;
          D     = INIT_VAL;
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == '1) state_d = ST_RUN;
        end
        ST_RUN: begin
          init_done = 1'b1;
          req_rdy   = req_wr | rd_room;
          if (req_vld && req_rdy) begin
            CEN = 1'b0;
            A   = req_addr;
            if (req_wr) begin
              GWEN = 1'b0;
              D    = req_wdata;
              for (int unsigned i = 0; i < BE_W; i++) WEN[8*i +: 8] = {8{~req_be[i]}};
            end else begin
              inflight_d = 1'b1;
            end
          end
          // Clear is honoured only when no read data is still owed to the consumer.
          if (clr_vld && !inflight_q && (fifo_cnt == '0)) begin
            state_d = ST_INIT;
            ptr_d   = '0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  ct_spsram_ctrl_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (forever_cpuclk),
    .rst_n   (cpurst_b),
    .push_i  (inflight_q),
    .wdata_i (Q),
    .pop_i   (rsp_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

endmodule

// File: doc/ct_spsram_2048x32_ctrl.md
CT_SPSRAM_2048X32_CTRL -- requirements
Module: ct_spsram_2048x32_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM data width.
REQ-003 Parameter INIT_VAL, default 32'h0, value written to every entry by the clear sweep.
REQ-004 Clocking is fixed: one clock, and reset is asynchronous and active-low.
REQ-005 forever_cpuclk  in  1  sole clock; all state updates on rising edge.
REQ-006 cpurst_b  in  1  asynchronous active-low reset.
REQ-007 req_vld  in  1  access request valid.
REQ-008 req_wr  in  1  1=write, 0=read.
REQ-009 req_addr  in  11  word address.
REQ-010 req_wdata  in  32  write data.
REQ-011 req_be  in  4  byte enables; bit i covers data bits 8i+7:8i.
REQ-012 req_rdy  out  1  request accepted when req_vld&req_rdy.
REQ-013 rsp_vld  out  1  read data valid.
REQ-014 rsp_rdata  out  32  read data.
REQ-015 rsp_rdy  in  1  consumer accepts response when rsp_vld&rsp_rdy.
REQ-016 clr_vld  in  1  software clear-sweep request, single-cycle pulse.
REQ-017 init_done  out  1  high when no sweep is in progress.
REQ-018 A / CEN / GWEN / WEN / D  out  11/1/1/32/32  SRAM port; CEN, GWEN and WEN are active-low.
REQ-019 Q  in  32  SRAM read data, valid the cycle after a read access.

Function
REQ-020 States: INIT (sweep) and RUN; reset enters INIT with sweep pointer 0.
REQ-021 INIT: each cycle drive CEN=0, GWEN=0, WEN=all 0, A=pointer, D=INIT_VAL; pointer increments by 1; after A=2047 the FSM goes to RUN, so init_done=1 exactly 2048 cycles after reset release.
REQ-022 INIT: req_rdy=0, and clr_vld is ignored.
REQ-023 RUN: clr_vld is accepted only when inflight=0 and the FIFO is empty, which resets the pointer to 0 and enters INIT next cycle; otherwise clr_vld is dropped.
REQ-024 Access occurs in the accept cycle: SRAM outputs are combinational from req_* when req_vld&req_rdy.
REQ-025 Write: CEN=0, GWEN=0, WEN[8i+7:8i]={8{~req_be[i]}}, D=req_wdata.
REQ-026 Write with req_be=0 is still accepted with CEN=0 and leaves memory unchanged.
REQ-027 Read: CEN=0, GWEN=1, WEN=all 1; set inflight for the next cycle; Q is pushed into the 2-entry response FIFO at the end of that next cycle.
REQ-028 No access: CEN=1, GWEN=1, WEN=all 1, A=0, D=0.
REQ-029 rsp_vld=FIFO non-empty; rsp_rdata=FIFO head; the FIFO pops on rsp_vld&rsp_rdy.
REQ-030 Read-accept-to-rsp_vld latency is 2 cycles; responses are returned in request order.
REQ-031 RUN req_rdy for reads: count+inflight-(rsp_vld&rsp_rdy) < 2, which combinationally depends on rsp_rdy.
REQ-032 RUN req_rdy for writes is always 1, because writes do not use the FIFO.
REQ-033 With rsp_rdy held at 1, back-to-back reads sustain 1 read/cycle.
REQ-034 A read one cycle after a write to the same address returns the new data.
REQ-035 FIFO overflow or underflow is impossible by construction; the bench asserts it.

Reset
REQ-036 While cpurst_b=0: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0, CEN=1, GWEN=1, WEN=all 1, A=0, D=0, FIFO empty, inflight=0, pointer=0.
REQ-037 Reset mid-operation discards any inflight read and all FIFO contents; after release the sweep restarts at address 0.

Structure
REQ-038 Widths, FSM state encodings and the FIFO depth (2) belong in a shared constants package/header.
REQ-039 The 2-entry response FIFO is one sub-module, ct_spsram_ctrl_rsp_fifo; all other logic stays in the top module.

Verification
REQ-040 Reset release -> 2048 cycles of CEN=0/GWEN=0 covering A=0..2047, then init_done=1; a subsequent read of 0x7FF returns 0.
REQ-041 Write 0x123=0xDEADBEEF with be=4'hF, then write 0x123=0x00000011 with be=4'b0001, then read 0x123 -> rsp_rdata=0xDEADBE11 exactly 2 cycles after accept.
REQ-042 With rsp_rdy=0, issue 3 reads -> first two accepted, req_rdy=0 on the third; raise rsp_rdy -> the third is accepted in the same cycle as the first pop, and data returns in order.
REQ-043 8 back-to-back reads with rsp_rdy=1 -> req_rdy held at 1, and 8 consecutive rsp_vld beats starting 2 cycles after the first accept.
REQ-044 clr_vld with a read inflight -> ignored; clr_vld when idle -> init_done=0 for 2048 cycles, then all entries equal 0.
REQ-045 Assert cpurst_b=0 while 2 responses are buffered -> rsp_vld drops immediately, and the sweep restarts at A=0 after release.
